// File: rtl/down_counter.sv
// Loadable down-counter with a sticky underflow flag and periodic/one-shot modes.
// Sits beside the up-counter on the register bus and shares its enable/clear handshake style.
module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             clear_underflow,
    output logic [WIDTH-1:0] value,
    output logic             underflow,
    output logic             running,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_EXPIRED = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] value_nxt;
    logic [WIDTH-1:0] reload_nxt;
    logic             underflow_nxt;
    logic             uf_event;

    // Strobes are single-cycle and sampled on the rising edge; there is no backpressure.
    // An underflow is a decrement requested at zero, so the count never wraps.
    assign uf_event = (state == S_RUN) && enable && (value == '0) && !load;

    always_comb begin
        state_nxt  = state;
        value_nxt  = value;
        reload_nxt = reload;
        if (load) begin
            value_nxt  = load_value;
            reload_nxt = load_value;
            state_nxt  = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (enable) begin
                        if (value != '0) begin
                            value_nxt = value - 1'b1;
                        end else if (auto_reload) begin
                            value_nxt = reload;
                        end else begin
                            state_nxt = S_EXPIRED;
                        end
                    end
                end
                S_EXPIRED: value_nxt = '0;
                S_IDLE:    value_nxt = value;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Setting beats clearing when both land in the same cycle.
    always_comb begin
        underflow_nxt = underflow;
        if (uf_event) begin
            underflow_nxt = 1'b1;
        end else if (clear_underflow) begin
            underflow_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= S_IDLE;
            value     <= '0;
            reload    <= '0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            value     <= value_nxt;
            reload    <= reload_nxt;
            underflow <= underflow_nxt;
        end
    end

    assign running   = (state == S_RUN);
    assign zero      = (value == '0);
    assign dbg_state = state;

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
Loadable down-counter with sticky underflow flag. It is the counting-direction counterpart of the up-counter in the counter_system demo.
- Software or a controller loads a start value and enables decrementing.
- On passing zero it flags underflow. It then either reloads (periodic mode) or stops (one-shot mode).
- It sits beside the up-counter on the same register bus and uses the same enable/clear handshake style.

Parameters:
WIDTH, 8, bit width of value, load_value and the internal reload register.

Ports:
clk  input  1  system clock, all state changes on rising edge
res  input  1  asynchronous active-high reset
enable  input  1  decrement qualifier; one decrement per cycle while high and state is RUN
load  input  1  one-cycle strobe: capture load_value into value and reload register, enter RUN
load_value  input  WIDTH  start/reload value, sampled only when load=1
auto_reload  input  1  1 = periodic (reload on underflow), 0 = one-shot (stop on underflow)
clear_underflow  input  1  clears the underflow flag
value  output  WIDTH  current count (registered)
underflow  output  1  sticky flag, set on underflow event (registered)
running  output  1  1 while FSM is in RUN (registered state decode)
zero  output  1  combinational, value == 0

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on res: all registers clear immediately when res=1, independent of clk.
- Reset values:
  - value=0, reload register=0, underflow=0.
  - FSM=IDLE, so running=0 and zero=1.
- FSM states: IDLE, RUN, EXPIRED. Encoding is free; running is 1 only in RUN.
- load=1, in any state, has priority over counting:
  - value<=load_value; reload<=load_value; next state RUN.
  - No decrement in the load cycle, even if enable=1.
- IDLE: value holds; leave only via load.
- RUN, enable=0: value holds.
- RUN, enable=1, value!=0: value<=value-1, latency 1 cycle.
- RUN, enable=1, value==0 (underflow event):
  - underflow<=1.
  - auto_reload=1: value<=reload, stay RUN.
  - auto_reload=0: value stays 0, next state EXPIRED.
- EXPIRED: value held at 0, no counting, and enable is ignored. Leave only via load, which goes to RUN.
- clear_underflow=1 clears underflow to 0 in any state and does not change FSM state or value.
- Simultaneous underflow event and clear_underflow: set wins, underflow=1.
- Simultaneous load and clear_underflow: both take effect (load, underflow=0).
- Simultaneous load and underflow event: load wins; no underflow is flagged and the flag keeps its prior value unless it is cleared in the same cycle.
- Loading 0 in RUN: the first enabled cycle produces an underflow event immediately. In periodic mode with reload=0, underflow recurs every enabled cycle.
- Arithmetic: unsigned WIDTH-bit. Underflow is detected as value==0 with a decrement pending, so no wrap to 2**WIDTH-1 ever occurs.
- res asserted mid-count: immediate return to reset values; load is required to restart.

Test Plan:
- Reset: assert res asynchronously mid-cycle -> value=0, underflow=0, running=0, zero=1 before the next edge; enable alone produces no count.
- One-shot: load 3, auto_reload=0, enable=1 -> value 3,2,1,0.
  - Next cycle: underflow=1, state EXPIRED, running=0.
  - value stays 0 for 10 further cycles.
- Periodic: load 2, auto_reload=1, enable=1 -> value 2,1,0,2,1,0,2.
  - underflow set after the first 0 and stays set.
  - clear_underflow pulse -> underflow=0, then set again at the next wrap.
- Gating: load 5, toggle enable 1,0,1,0 -> value 5,4,4,3,3.
  - load with enable=1 -> value=load_value, with no decrement in that cycle.
- Collisions:
  - At the underflow cycle assert clear_underflow -> underflow=1.
  - At the underflow cycle assert load=9 -> value=9, underflow unchanged, running=1.
- Edge values: WIDTH=8, load 255 periodic -> 256 enabled cycles per underflow. Load 0 periodic -> underflow every enabled cycle, value stays 0.
